om_range_writer: RTL and testbench

Producer side of the object-metadata range buffer. Software writes an object's base address and byte size through a small configuration port. The block computes the inclusive range [first, last], queues it in a short FIFO, and emits one write record per cycle toward the range buffer (`en_write`/`first`/`last`). It also generates the buffer's synchronous clear pulse. It sits between the core's CSR/MMIO decode and the range buffer in the memory-safety checker.

---
 rtl/om_pkg.sv | 27 ++
 rtl/om_range_fifo.sv | 60 ++++++
 rtl/om_range_writer.sv | 122 ++++++++++++
 tb/tb_om_range_writer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/om_pkg.sv
// Shared types for the object-metadata range writer: record layout, config
// commands, error-bit indices and FSM states.
package om_pkg;

    typedef struct packed {
        logic [31:0] first;
        logic [31:0] last;
    } om_range_t;

    typedef enum logic [1:0] {
        CMD_BASE  = 2'd0,
        CMD_SIZE  = 2'd1,
        CMD_CLEAR = 2'd2,
        CMD_RSVD  = 2'd3
    } om_cfg_cmd_e;

    localparam int ERR_SEQ  = 0;
    localparam int ERR_ZERO = 1;
    localparam int ERR_FULL = 2;
    localparam int ERR_OVF  = 3;

    typedef enum logic {
        ST_IDLE,
        ST_HAVE_BASE
    } om_state_e;

endpackage

// File: rtl/om_range_fifo.sv
// Synchronous om_range_t FIFO with push/pop/flush; head visible combinationally.
// Latency: a push is visible at the head the cycle after; flush wins over push/pop.
module om_range_fifo
    import om_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  om_range_t                  push_dat_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output om_range_t                  head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);

    om_range_t          r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full_o    = (r_count == (AW+1)'(DEPTH));
    assign empty_o   = (r_count == '0);
    assign count_o   = r_count;
    assign head_o    = r_mem[r_rd_ptr];
    assign w_do_push = push_i && !full_o;
    assign w_do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_dat_i;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/om_range_writer.sv
// Producer side of the object-metadata range buffer: BASE/SIZE config -> [first,last] records.
// Records emit the cycle after SIZE; en_write_o = FIFO non-empty & wr_ready_i. Optional OM_RANGE_OVERFLOW_CHECK_EN.
module om_range_writer
    import om_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cfg_we_i,
    input  logic [1:0]       cfg_sel_i,
    input  logic [31:0]      cfg_wdata_i,
    input  logic             wr_ready_i,
    output logic             en_write_o,
    output logic [31:0]      addr_first_o,
    output logic [31:0]      addr_last_o,
    output logic             clear_o,
    output logic             busy_o,
    output logic [3:0]       err_o,
    output logic [CNT_W-1:0] rec_count_o
);

    om_state_e          r_state;
    om_state_e          w_state_nxt;
    logic [31:0]        r_base;
    logic [3:0]         r_err;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_clear;

    om_cfg_cmd_e        w_cmd;
    logic               w_is_base, w_is_size, w_is_clear, w_is_rsvd;
    logic [31:0]        w_last;
    logic               w_zero, w_ovf, w_size_ok, w_push;
    logic [3:0]         w_err_set;
    om_range_t          w_push_dat, w_head;
    logic               w_full, w_empty;
    logic [$clog2(DEPTH):0] w_count;

    assign w_cmd      = om_cfg_cmd_e'(cfg_sel_i);
    assign w_is_base  = cfg_we_i && (w_cmd == CMD_BASE);
    assign w_is_size  = cfg_we_i && (w_cmd == CMD_SIZE);
    assign w_is_clear = cfg_we_i && (w_cmd == CMD_CLEAR);
    assign w_is_rsvd  = cfg_we_i && (w_cmd == CMD_RSVD);
    assign w_zero     = (cfg_wdata_i == 32'd0);

`ifdef OM_RANGE_OVERFLOW_CHECK_EN
    logic [32:0] w_sum;
    assign w_sum  = {1'b0, r_base} + {1'b0, cfg_wdata_i} - 33'd1;
    assign w_last = w_sum[31:0];
    // Zero size is reported as ERR_ZERO only, not also as an overflow.
    assign w_ovf  = w_sum[32] && !w_zero;
`else
    assign w_last = r_base + cfg_wdata_i - 32'd1;
    assign w_ovf  = 1'b0;
`endif

    assign w_size_ok  = w_is_size && (r_state == ST_HAVE_BASE) && !w_zero && !w_ovf;
    assign w_push     = w_size_ok && !w_full;
    assign w_push_dat = '{first: r_base, last: w_last};

    always_comb begin
        w_err_set           = '0;
        w_err_set[ERR_SEQ]  = w_is_rsvd || (w_is_size && r_state == ST_IDLE);
        w_err_set[ERR_ZERO] = w_is_size && (r_state == ST_HAVE_BASE) && w_zero;
        w_err_set[ERR_OVF]  = w_is_size && (r_state == ST_HAVE_BASE) && w_ovf;
        w_err_set[ERR_FULL] = w_size_ok && w_full;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_is_clear)      w_state_nxt = ST_IDLE;
        else if (w_is_base)  w_state_nxt = ST_HAVE_BASE;
        else if (w_is_size)  w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    om_range_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (w_push),
        .push_dat_i (w_push_dat),
        .pop_i      (en_write_o),
        .flush_i    (w_is_clear),
        .head_o     (w_head),
        .full_o     (w_full),
        .empty_o    (w_empty),
        .count_o    (w_count)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_base  <= '0;
            r_err   <= '0;
            r_cnt   <= '0;
            r_clear <= 1'b0;
        end else begin
            r_clear <= w_is_clear;
            if (w_is_base) r_base <= cfg_wdata_i;
            if (w_is_clear) begin
                r_err <= '0;
                r_cnt <= '0;
            end else begin
                r_err <= r_err | w_err_set;
                if (en_write_o && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign en_write_o   = !w_empty && wr_ready_i;
    assign addr_first_o = w_empty ? 32'd0 : w_head.first;
    assign addr_last_o  = w_empty ? 32'd0 : w_head.last;
    assign clear_o      = r_clear;
    assign busy_o       = (r_state == ST_HAVE_BASE) || (w_count != '0);
    assign err_o        = r_err;
    assign rec_count_o  = r_cnt;

endmodule

// File: tb/tb_om_range_writer.sv
// Scoreboarded bench for om_range_writer: expected records queued on SIZE, checked on en_write_o.
module tb_om_range_writer;
    import om_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [1:0]  cfg_sel;
    logic [31:0] cfg_wdata;
    logic        wr_ready;
    logic        en_write;
    logic [31:0] addr_first, addr_last;
    logic        clear;
    logic        busy;
    logic [3:0]  err;
    logic [15:0] rec_count;

    int checks = 0;
    int errors = 0;
    om_range_t sb [$];

    always #5 clk = ~clk;

    om_range_writer #(.DEPTH(4), .CNT_W(16)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .cfg_we_i     (cfg_we),
        .cfg_sel_i    (cfg_sel),
        .cfg_wdata_i  (cfg_wdata),
        .wr_ready_i   (wr_ready),
        .en_write_o   (en_write),
        .addr_first_o (addr_first),
        .addr_last_o  (addr_last),
        .clear_o      (clear),
        .busy_o       (busy),
        .err_o        (err),
        .rec_count_o  (rec_count)
    );

    // Every transfer is matched against the oldest expected record.
    always @(negedge clk) begin
        if (rst_n && en_write) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got first=%h last=%h, required no write", addr_first, addr_last);
            end else begin
                om_range_t exp_r;
                exp_r = sb.pop_front();
                if (addr_first !== exp_r.first || addr_last !== exp_r.last) begin
                    errors++;
                    $display("FAIL record: got %h..%h, required %h..%h", addr_first, addr_last, exp_r.first, exp_r.last);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg(input logic [1:0] sel, input logic [31:0] data);
        cfg_we = 1'b1; cfg_sel = sel; cfg_wdata = data;
        tick(1);
        cfg_we = 1'b0;
    endtask

    task automatic pair(input logic [31:0] base, input logic [31:0] size, input bit expect_push);
        om_range_t r;
        cfg(2'd0, base);
        cfg(2'd1, size);
        r.first = base;
        r.last  = base + size - 32'd1;
        if (expect_push) sb.push_back(r);
    endtask

    task automatic test_reset;
        checks++;
        if ({en_write, clear, busy, err, rec_count, addr_first, addr_last} !== '0) begin
            errors++;
            $display("FAIL reset_state: got en=%b clr=%b busy=%b err=%b cnt=%0d first=%h last=%h, required all 0",
                     en_write, clear, busy, err, rec_count, addr_first, addr_last);
        end
    endtask

    task automatic test_basic;
        wr_ready = 1'b1;
        pair(32'h8000_1000, 32'h40, 1'b1);
        checks++;
        if (en_write !== 1'b1) begin
            errors++;
            $display("FAIL basic_latency: got en_write=%b, required 1", en_write);
        end
        tick(2);
        checks++;
        if (rec_count !== 16'd1 || busy !== 1'b0 || err !== 4'b0000) begin
            errors++;
            $display("FAIL basic_after: got cnt=%0d busy=%b err=%b, required 1 0 0000", rec_count, busy, err);
        end
    endtask

    task automatic test_errors;
        cfg(2'd1, 32'h10);
        tick(1);
        checks++;
        if (err !== 4'b0001 || busy !== 1'b0) begin
            errors++;
            $display("FAIL err_seq: got err=%b busy=%b, required 0001 0", err, busy);
        end
        pair(32'h1234_0000, 32'h0, 1'b0);
        tick(1);
        checks++;
        if (err !== 4'b0011 || rec_count !== 16'd1) begin
            errors++;
            $display("FAIL err_zero: got err=%b cnt=%0d, required 0011 1", err, rec_count);
        end
    endtask

    task automatic test_clear;
        wr_ready = 1'b0;
        for (int i = 0; i < 3; i++) pair(32'h100 * (i + 1), 32'h8, 1'b0);
        checks++;
        if (busy !== 1'b1 || addr_first !== 32'h100 || en_write !== 1'b0) begin
            errors++;
            $display("FAIL clear_pre: got busy=%b first=%h en=%b, required 1 00000100 0", busy, addr_first, en_write);
        end
        cfg(2'd2, 32'h0);
        checks++;
        if (clear !== 1'b1 || busy !== 1'b0 || err !== 4'b0 || rec_count !== 16'd0 || addr_first !== 32'd0) begin
            errors++;
            $display("FAIL clear_post: got clr=%b busy=%b err=%b cnt=%0d first=%h, required 1 0 0000 0 0",
                     clear, busy, err, rec_count, addr_first);
        end
        tick(1);
        checks++;
        if (clear !== 1'b0) begin
            errors++;
            $display("FAIL clear_pulse_len: got clr=%b, required 0", clear);
        end
        wr_ready = 1'b1;
        tick(3);
    endtask

    task automatic test_full;
        wr_ready = 1'b0;
        for (int i = 0; i < 5; i++) pair(32'h2000_0000 + 32'h100 * i, 32'h10 + i, i < 4);
        tick(1);
        checks++;
        if (err !== 4'b0100 || en_write !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL full_reject: got err=%b en=%b busy=%b, required 0100 0 1", err, en_write, busy);
        end
        wr_ready = 1'b1;
        tick(6);
        checks++;
        if (rec_count !== 16'd4 || sb.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL full_drain: got cnt=%0d pending=%0d busy=%b, required 4 0 0", rec_count, sb.size(), busy);
        end
    endtask

    task automatic test_overflow;
        wr_ready = 1'b1;
`ifdef OM_RANGE_OVERFLOW_CHECK_EN
        pair(32'hFFFF_FFF0, 32'h20, 1'b0);
        tick(2);
        checks++;
        if (err !== 4'b1100 || rec_count !== 16'd4) begin
            errors++;
            $display("FAIL overflow: got err=%b cnt=%0d, required 1100 4", err, rec_count);
        end
`else
        pair(32'hFFFF_FFF0, 32'h20, 1'b1);
        tick(2);
        checks++;
        if (err !== 4'b0100 || rec_count !== 16'd5 || sb.size() != 0) begin
            errors++;
            $display("FAIL overflow_wrap: got err=%b cnt=%0d pending=%0d, required 0100 5 0", err, rec_count, sb.size());
        end
`endif
    endtask

    task automatic test_back_to_back;
        logic [15:0] start;
        wr_ready = 1'b1;
        start = rec_count;
        for (int i = 0; i < 4; i++) pair(32'h4000_0000 + 32'h1000 * i, 32'h80 * (i + 1), 1'b1);
        tick(1);
        checks++;
        if (rec_count !== start + 16'd4 || sb.size() != 0) begin
            errors++;
            $display("FAIL back_to_back: got cnt=%0d pending=%0d, required %0d 0", rec_count, sb.size(), start + 16'd4);
        end
    endtask

    task automatic test_reset_mid;
        wr_ready = 1'b0;
        pair(32'h5000_0000, 32'h4, 1'b0);
        pair(32'h6000_0000, 32'h4, 1'b0);
        cfg(2'd0, 32'h7000_0000);
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        checks++;
        if ({en_write, clear, busy, err, rec_count, addr_first, addr_last} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got en=%b busy=%b err=%b cnt=%0d first=%h, required all 0",
                     en_write, busy, err, rec_count, addr_first);
        end
        wr_ready = 1'b1;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        cfg(2'd1, 32'h10);
        tick(1);
        checks++;
        if (err !== 4'b0001 || busy !== 1'b0 || rec_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_seq: got err=%b busy=%b cnt=%0d, required 0001 0 0", err, busy, rec_count);
        end
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_sel = 2'd0; cfg_wdata = '0; wr_ready = 1'b0;
        #22 rst_n = 1'b1;
        tick(1);
        test_reset;
        test_basic;
        test_errors;
        test_clear;
        test_full;
        test_overflow;
        test_back_to_back;
        test_reset_mid;
        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
